// File: rtl/pdu_pkg.sv
// Shared definitions for the key event controller: arbiter state encoding
// and the default sample-tick divider.
package pdu_pkg;

  // Arbiter states: IDLE looks for pending presses, OFFER holds one until accepted.
  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  // Default number of clk cycles per debounce sample tick.
  localparam int DEFAULT_TICK_DIV = 50000;

endpackage

// File: rtl/key_filter.sv
// Per-key debounce filter: 2-flop synchronizer, stable-tick counter and
// debounced level register. rise pulses in the cycle whose clock edge
// takes the level from 0 to 1.
module key_filter #(
  parameter int STABLE_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int SW = $clog2(STABLE_TICKS + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_TICKS);

  logic          sync1;
  logic          sync2;
  logic [SW-1:0] stable_cnt;
  logic [SW-1:0] stable_inc;
  logic          differs;
  logic          accept;

  assign differs    = (sync2 != level);
  assign stable_inc = stable_cnt + 1'b1;
  assign accept     = tick && differs && (stable_inc == STABLE_MAX);
  assign rise       = accept && !level;

  // Two-stage synchronizer for the asynchronous button level.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its source; blocking here would collapse the two stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Count consecutive disagreeing ticks; toggle the level once enough accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_cnt <= '0;
      level      <= 1'b0;
    end else if (tick) begin
      if (!differs) begin
        stable_cnt <= '0;
      end else if (accept) begin
        stable_cnt <= '0;
        level      <= ~level;
      end else begin
        stable_cnt <= stable_inc;
      end
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Debounced button controller: shared sample tick, one key_filter per key,
// a pending-press register and a round-robin arbiter that offers one press
// event at a time over a valid/ready handshake.
module key_event_ctrl
  import pdu_pkg::*;
#(
  parameter int N_KEYS       = 5,
  parameter int TICK_DIV     = DEFAULT_TICK_DIV,
  parameter int STABLE_TICKS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic              evt_valid,
  output logic [2:0]        evt_id,
  input  logic              evt_ready,
  output logic              evt_drop
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [2:0]    LAST_ID  = 3'(N_KEYS - 1);

  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic [N_KEYS-1:0] rise;
  logic [N_KEYS-1:0] pending;
  logic [N_KEYS-1:0] pending_nxt;
  logic [N_KEYS-1:0] clr_mask;
  logic              drop_set;
  logic [2:0]        rr_ptr;
  logic [2:0]        rr_nxt;
  logic [2:0]        id_nxt;
  logic              handshake;
  arb_state_t        state;
  arb_state_t        state_nxt;

  logic              found_hi;
  logic              found_any;
  logic [2:0]        pick_hi;
  logic [2:0]        pick_any;
  logic [2:0]        pick;

  assign tick = (tick_cnt == TICK_MAX);

  // Free-running sample divider shared by all keys.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_filter #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_filter (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .raw  (key_in[g]),
      .level(key_level[g]),
      .rise (rise[g])
    );
  end

  // Round-robin search: lowest pending index at or above rr_ptr, else lowest overall.
  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    found_hi  = 1'b0;
    found_any = 1'b0;
    pick_hi   = '0;
    pick_any  = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        found_any = 1'b1;
        pick_any  = 3'(i);
        if (3'(i) >= rr_ptr) begin
          found_hi = 1'b1;
          pick_hi  = 3'(i);
        end
      end
    end
    pick = found_hi ? pick_hi : pick_any;
  end

  // Arbiter next-state and outputs.
  always_comb begin
    state_nxt = state;
    id_nxt    = evt_id;
    rr_nxt    = rr_ptr;
    handshake = 1'b0;
    evt_valid = 1'b0;
    case (state)
      IDLE: begin
        if (found_any) begin
          id_nxt    = pick;
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        evt_valid = 1'b1;
        if (evt_ready) begin
          handshake = 1'b1;
          rr_nxt    = (evt_id == LAST_ID) ? 3'd0 : evt_id + 3'd1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pending update: a new press wins over the handshake clear of the same key;
  // a press landing on a still-pending key is coalesced and flagged.
  always_comb begin
    clr_mask = '0;
    if (handshake) begin
      clr_mask[evt_id] = 1'b1;
    end
    pending_nxt = (pending & ~clr_mask) | rise;
    drop_set    = |(rise & pending & ~clr_mask);
  end

  // Arbiter state, offered id, round-robin pointer, pending set and drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      evt_id   <= '0;
      rr_ptr   <= '0;
      pending  <= '0;
      evt_drop <= 1'b0;
    end else begin
      state    <= state_nxt;
      evt_id   <= id_nxt;
      rr_ptr   <= rr_nxt;
      pending  <= pending_nxt;
      evt_drop <= evt_drop | drop_set;
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with a scoreboard of expected event ids.
module tb_key_event_ctrl;

  localparam int N_KEYS       = 5;
  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] key_level;
  logic              evt_valid;
  logic [2:0]        evt_id;
  logic              evt_ready;
  logic              evt_drop;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int rises1 = 0;
  int cyc = 0;
  logic prev1 = 1'b0;
  int sb[$];
  int hs_cyc[$];

  key_event_ctrl #(
    .N_KEYS      (N_KEYS),
    .TICK_DIV    (TICK_DIV),
    .STABLE_TICKS(STABLE_TICKS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .key_level(key_level),
    .evt_valid(evt_valid),
    .evt_id   (evt_id),
    .evt_ready(evt_ready),
    .evt_drop (evt_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake monitor: pops the scoreboard for each accepted event.
  always @(negedge clk) begin
    if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
      int exp_id;
      hs_count++;
      hs_cyc.push_back(cyc);
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL hs_unexpected observed id=%0d expected no event", evt_id);
      end
      if (sb.size() != 0) begin
        exp_id = sb.pop_front();
        checks++;
        assert (int'(evt_id) === exp_id) else begin
          errors++;
          $error("FAIL hs_id observed=%0d expected=%0d", evt_id, exp_id);
        end
      end
    end
    if (key_level[1] === 1'b1 && prev1 === 1'b0) rises1++;
    prev1 = key_level[1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int i = 0;
    while (evt_valid !== 1'b1 && i < budget) begin
      step(1);
      i++;
    end
    check(tag, 32'(evt_valid), 32'd1);
  endtask

  task automatic wait_levels(input string tag, input logic [N_KEYS-1:0] exp, input int budget);
    int i = 0;
    while (key_level !== exp && i < budget) begin
      step(1);
      i++;
    end
    check(tag, 32'(key_level), 32'(exp));
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int i = 0;
    while (sb.size() != 0 && i < budget) begin
      step(1);
      i++;
    end
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int hc;
    rst       = 1'b1;
    key_in    = '0;
    evt_ready = 1'b0;
    step(3);
    // Reset state
    check("rst_level", 32'(key_level), 32'd0);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_drop", 32'(evt_drop), 32'd0);
    check("rst_id", 32'(evt_id), 32'd0);
    rst = 1'b0;

    // Clean press on key 2
    key_in = 5'b00100;
    sb.push_back(2);
    wait_levels("t1_level", 5'b00100, 40);
    step(2);
    check("t1_valid", 32'(evt_valid), 32'd1);
    check("t1_id", 32'(evt_id), 32'd2);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    check("t1_hs_count", 32'(hs_count), 32'd1);
    check("t1_valid_low", 32'(evt_valid), 32'd0);
    step(30);
    check("t1_no_second", 32'(evt_valid), 32'd0);
    key_in = '0;
    wait_levels("t1_release", 5'b00000, 40);
    step(5);
    check("t1_no_release_evt", 32'(evt_valid), 32'd0);

    // Bouncing key 1, then stable high
    sb.push_back(1);
    for (int s = 0; s < 8; s++) begin
      key_in[1] = (s % 2 == 0);
      step(5);
    end
    check("t2_no_early_level", 32'(key_level), 32'd0);
    key_in[1] = 1'b1;
    wait_valid("t2_valid", 60);
    check("t2_id", 32'(evt_id), 32'd1);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    step(20);
    check("t2_single_rise", 32'(rises1), 32'd1);
    check("t2_level", 32'(key_level), 32'b00010);
    check("t2_hs_count", 32'(hs_count), 32'd2);
    key_in = '0;
    wait_levels("t2_release", 5'b00000, 40);

    // Simultaneous presses on 0, 3, 4 with rr_ptr back at 0, ready tied high
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    hs_cyc.delete();
    evt_ready = 1'b1;
    key_in = 5'b11001;
    sb.push_back(0);
    sb.push_back(3);
    sb.push_back(4);
    wait_drain("t3_drain", 60);
    check("t3_hs_n", 32'(hs_cyc.size()), 32'd3);
    if (hs_cyc.size() == 3) begin
      check("t3_gap_a", 32'(hs_cyc[1] - hs_cyc[0]), 32'd2);
      check("t3_gap_b", 32'(hs_cyc[2] - hs_cyc[1]), 32'd2);
    end
    evt_ready = 1'b0;
    key_in = '0;
    wait_levels("t3_release", 5'b00000, 40);

    // Press, release, re-press key 3 while the consumer stalls
    key_in = 5'b01000;
    sb.push_back(3);
    wait_valid("t4_valid", 40);
    check("t4_id", 32'(evt_id), 32'd3);
    key_in = '0;
    wait_levels("t4_rel", 5'b00000, 40);
    check("t4_hold_valid", 32'(evt_valid), 32'd1);
    check("t4_hold_id", 32'(evt_id), 32'd3);
    check("t4_no_drop_yet", 32'(evt_drop), 32'd0);
    key_in = 5'b01000;
    wait_levels("t4_repress", 5'b01000, 40);
    step(1);
    check("t4_drop", 32'(evt_drop), 32'd1);
    check("t4_still_id", 32'(evt_id), 32'd3);
    hc = hs_count;
    evt_ready = 1'b1;
    step(1);
    step(20);
    check("t4_one_event", 32'(hs_count), 32'(hc + 1));
    check("t4_idle", 32'(evt_valid), 32'd0);
    check("t4_drop_sticky", 32'(evt_drop), 32'd1);
    evt_ready = 1'b0;

    // Reset during OFFER discards the event
    key_in = '0;
    wait_levels("t5_release", 5'b00000, 40);
    key_in = 5'b00100;
    wait_valid("t5_valid", 40);
    check("t5_id", 32'(evt_id), 32'd2);
    hc = hs_count;
    rst = 1'b1;
    key_in = '0;
    step(1);
    rst = 1'b0;
    check("t5_rst_valid", 32'(evt_valid), 32'd0);
    check("t5_rst_level", 32'(key_level), 32'd0);
    check("t5_rst_drop", 32'(evt_drop), 32'd0);
    check("t5_rst_id", 32'(evt_id), 32'd0);
    evt_ready = 1'b1;
    step(40);
    check("t5_quiet", 32'(evt_valid), 32'd0);
    check("t5_no_hs", 32'(hs_count), 32'(hc));
    key_in = 5'b10000;
    sb.push_back(4);
    wait_drain("t5_new_press", 40);
    check("t5_hs_after", 32'(hs_count), 32'(hc + 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
